vx_dot8_arbiter: RTL and testbench

- Shares one fixed-latency DOT8 processing element (4x unsigned 8-bit multiply, sum into 32 bits) between NUM_REQS issue requesters.
- Arbitrates requests round-robin and drives the PE's input and pipeline enable.
- Tracks each in-flight operation's owner and tag in a shadow pipeline aligned with the PE.
- Returns results on a single registered response channel with valid/ready backpressure; backpressure stalls the shared PE.

---
 rtl/vx_dot8_arbiter.sv | 93 +++++++++
 tb/tb_vx_dot8_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_dot8_arbiter.sv
// vx_dot8_arbiter: round-robin sharing of one fixed-latency DOT8 PE among NUM_REQS requesters,
// with a shadow owner/tag pipe and a registered, backpressured response channel.
module vx_dot8_arbiter #(
  parameter int NUM_REQS     = 4,
  parameter int DATA_WIDTH   = 64,
  parameter int RESULT_WIDTH = 32,
  parameter int TAG_WIDTH    = 8,
  parameter int LATENCY      = 2,
  parameter int IDX_WIDTH    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQS-1:0]            req_valid,
  input  logic [NUM_REQS*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag,
  output logic [NUM_REQS-1:0]            req_ready,
  output logic                           pe_enable,
  output logic [DATA_WIDTH-1:0]          pe_data_in,
  input  logic [RESULT_WIDTH-1:0]        pe_data_out,
  output logic                           rsp_valid,
  output logic [RESULT_WIDTH-1:0]        rsp_data,
  output logic [TAG_WIDTH-1:0]           rsp_tag,
  output logic [IDX_WIDTH-1:0]           rsp_idx,
  input  logic                           rsp_ready,
  output logic                           idle,
  output logic [31:0]                    stall_count
);
  logic [IDX_WIDTH-1:0] ptr, winner, cand;
  logic                 grant;
  logic [LATENCY-1:0]   sh_valid;
  logic [IDX_WIDTH-1:0] sh_idx [LATENCY];
  logic [TAG_WIDTH-1:0] sh_tag [LATENCY];

  // A held response freezes the whole PE pipe; reset also holds it still.
  assign pe_enable = reset & (~rsp_valid | rsp_ready);
  assign idle      = ~rsp_valid & ~|sh_valid;

  // Scan downward so the candidate nearest ptr+1 is assigned last and wins.
  always_comb begin
    grant  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = NUM_REQS; k >= 1; k--) begin
      cand = IDX_WIDTH'((int'(ptr) + k) % NUM_REQS);
      if (req_valid[cand]) begin
        grant  = pe_enable;
        winner = cand;
      end
    end
    req_ready  = grant ? NUM_REQS'(1) << winner : '0;
    pe_data_in = grant ? req_data[winner*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr         <= IDX_WIDTH'(NUM_REQS - 1);
      sh_valid    <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_tag     <= '0;
      rsp_idx     <= '0;
      stall_count <= '0;
    end else begin
      if (grant)
        ptr <= winner;
      if (|req_valid && !grant && stall_count != '1)
        stall_count <= stall_count + 32'd1;
      if (pe_enable) begin
        sh_valid[0] <= grant;
        for (int k = 1; k < LATENCY; k++)
          sh_valid[k] <= sh_valid[k-1];
        rsp_valid <= sh_valid[LATENCY-1];
        if (sh_valid[LATENCY-1]) begin
          rsp_data <= pe_data_out;
          rsp_tag  <= sh_tag[LATENCY-1];
          rsp_idx  <= sh_idx[LATENCY-1];
        end
      end
    end
  end

  // Owner/tag payload needs no reset: it is only consumed behind sh_valid.
  always_ff @(posedge clk) begin
    if (pe_enable) begin
      sh_idx[0] <= winner;
      sh_tag[0] <= req_tag[winner*TAG_WIDTH +: TAG_WIDTH];
      for (int k = 1; k < LATENCY; k++) begin
        sh_idx[k] <= sh_idx[k-1];
        sh_tag[k] <= sh_tag[k-1];
      end
    end
  end
endmodule

// File: tb/tb_vx_dot8_arbiter.sv
// tb_vx_dot8_arbiter: drives vx_dot8_arbiter with a 2-stage DOT8 PE model and a grant-order scoreboard.
module tb_vx_dot8_arbiter;
  logic         clk;
  logic         reset;
  logic [3:0]   req_valid;
  logic [255:0] req_data;
  logic [31:0]  req_tag;
  logic [3:0]   req_ready;
  logic         pe_enable;
  logic [63:0]  pe_data_in;
  logic [31:0]  pe_data_out;
  logic         rsp_valid;
  logic [31:0]  rsp_data;
  logic [7:0]   rsp_tag;
  logic [1:0]   rsp_idx;
  logic         rsp_ready;
  logic         idle;
  logic [31:0]  stall_count;
  int total = 0;
  int bad = 0;

  typedef struct packed {
    logic [1:0]  idx;
    logic [7:0]  tag;
    logic [31:0] data;
  } exp_t;
  exp_t q[$];

  vx_dot8_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data), .req_tag(req_tag),
    .req_ready(req_ready), .pe_enable(pe_enable), .pe_data_in(pe_data_in), .pe_data_out(pe_data_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_idx(rsp_idx),
    .rsp_ready(rsp_ready), .idle(idle), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] dot8(input logic [63:0] d);
    logic [31:0] s;
    s = 32'd0;
    for (int b = 0; b < 4; b++) s = s + 32'(d[8*b +: 8]) * 32'(d[32+8*b +: 8]);
    return s;
  endfunction

  logic [31:0] pe_pipe [2];
  always @(posedge clk)
    if (pe_enable) begin
      pe_pipe[0] <= dot8(pe_data_in);
      pe_pipe[1] <= pe_pipe[0];
    end
  assign pe_data_out = pe_pipe[1];

  // Scoreboard: push on accepted request, pop on accepted response.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!reset) q.delete();
    else begin
      if (rsp_valid && rsp_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra got idx=%0d tag=%h data=%h want none", rsp_idx, rsp_tag, rsp_data);
        end else begin
          e = q.pop_front();
          if ({rsp_idx, rsp_tag, rsp_data} !== e) begin
            bad++;
            $display("FAIL sb_rsp got idx=%0d tag=%h data=%h want idx=%0d tag=%h data=%h",
                     rsp_idx, rsp_tag, rsp_data, e.idx, e.tag, e.data);
          end
        end
      end
      for (int i = 0; i < 4; i++)
        if (req_valid[i] && req_ready[i])
          q.push_back({2'(i), req_tag[i*8 +: 8], dot8(req_data[i*64 +: 64])});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 4'hF; rsp_ready = 1'b1;
    repeat (2) tick();
    sample();
    total++; if (req_ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
    total++; if (pe_enable !== 1'b0) begin bad++; $display("FAIL reset_pe_enable got=%b want=0", pe_enable); end
    total++; if ({rsp_valid, idle} !== 2'b01) begin bad++; $display("FAIL reset_valid_idle got=%b want=01", {rsp_valid, idle}); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL reset_stall got=%0d want=0", stall_count); end
    total++; if ({rsp_data, rsp_tag, rsp_idx} !== 42'd0) begin bad++; $display("FAIL reset_rsp got=%h want=0", {rsp_data, rsp_tag, rsp_idx}); end
    tick();
    reset = 1'b1; req_valid = 4'h0;
  endtask

  task automatic test_round_robin();
    logic [31:0] sc0;
    sc0 = stall_count;
    for (int i = 0; i < 4; i++) begin
      req_data[i*64 +: 64] = {$urandom(), $urandom()};
      req_tag[i*8 +: 8] = 8'(8'h10 + i);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      req_valid = (k < 8) ? 4'hF : 4'h0;
      sample();
      if (k < 8) begin
        total++;
        if (req_ready !== 4'(1 << (k % 4))) begin bad++; $display("FAIL rr_grant k=%0d got=%b want=%b", k, req_ready, 4'(1 << (k % 4))); end
      end
      if (k >= 3) begin
        total++;
        if (rsp_valid !== 1'b1 || rsp_idx !== 2'((k - 3) % 4)) begin
          bad++; $display("FAIL rr_rsp k=%0d got v=%b idx=%0d want v=1 idx=%0d", k, rsp_valid, rsp_idx, (k - 3) % 4);
        end
      end
    end
    total++; if (stall_count !== sc0) begin bad++; $display("FAIL rr_stall got=%0d want=%0d", stall_count, sc0); end
  endtask

  task automatic test_single();
    tick();
    req_valid = 4'b0001; req_data[63:0] = 64'h01010101_04030201; req_tag[7:0] = 8'h5A; rsp_ready = 1'b1;
    sample();
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", req_ready); end
    total++; if (pe_data_in !== 64'h01010101_04030201) begin bad++; $display("FAIL single_pe_in got=%h want=0101010104030201", pe_data_in); end
    tick();
    req_valid = 4'b0;
    sample();
    total++; if (pe_data_in !== 64'd0) begin bad++; $display("FAIL single_pe_idle got=%h want=0", pe_data_in); end
    total++; if ({rsp_valid, idle} !== 2'b00) begin bad++; $display("FAIL single_t1 got v,idle=%b want=00", {rsp_valid, idle}); end
    tick(); sample();
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_t2 got v=%b want=0", rsp_valid); end
    tick(); sample();
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000000A || rsp_idx !== 2'd0 || rsp_tag !== 8'h5A) begin
      bad++; $display("FAIL single_rsp got v=%b data=%h idx=%0d tag=%h want v=1 data=0000000a idx=0 tag=5a", rsp_valid, rsp_data, rsp_idx, rsp_tag);
    end
    tick(); sample();
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL single_idle got=%b want=1", idle); end
  endtask

  task automatic test_backpressure();
    logic [31:0] sc0, hd;
    logic [7:0] ht;
    logic [1:0] hi;
    logic got;
    got = 1'b1; sc0 = '0; hd = '0; ht = '0; hi = '0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (k == 4) sc0 = stall_count;
      req_valid = (k < 12) ? 4'b0010 : 4'b0000;
      if (got) begin
        req_data[64 +: 64] = {$urandom(), $urandom()};
        req_tag[8 +: 8] = 8'(8'h80 + k);
      end
      rsp_ready = !(k >= 4 && k <= 8);
      sample();
      got = req_ready[1];
      if (k == 4) begin
        hd = rsp_data; ht = rsp_tag; hi = rsp_idx;
        total++; if (rsp_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid got=%b want=1", rsp_valid); end
      end
      if (k >= 4 && k <= 8) begin
        total++;
        if (req_ready !== 4'b0 || pe_enable !== 1'b0) begin
          bad++; $display("FAIL bp_freeze k=%0d got ready=%b en=%b want ready=0000 en=0", k, req_ready, pe_enable);
        end
      end
      if (k > 4 && k <= 8) begin
        total++;
        if ({rsp_valid, rsp_data, rsp_tag, rsp_idx} !== {1'b1, hd, ht, hi}) begin
          bad++; $display("FAIL bp_stable k=%0d got data=%h tag=%h idx=%0d want data=%h tag=%h idx=%0d", k, rsp_data, rsp_tag, rsp_idx, hd, ht, hi);
        end
      end
      if (k == 9) begin
        total++; if (stall_count !== sc0 + 32'd5) begin bad++; $display("FAIL bp_stall got=%0d want=%0d", stall_count, sc0 + 32'd5); end
      end
    end
  endtask

  task automatic test_max();
    tick();
    req_valid = 4'b1000; req_data[192 +: 64] = '1; req_tag[24 +: 8] = 8'hEE; rsp_ready = 1'b1;
    sample();
    tick();
    req_valid = 4'b0;
    sample();
    for (int n = 0; n < 8 && rsp_valid !== 1'b1; n++) begin tick(); sample(); end
    total++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h0003F804 || rsp_idx !== 2'd3 || rsp_tag !== 8'hEE) begin
      bad++; $display("FAIL max_rsp got v=%b data=%h idx=%0d tag=%h want v=1 data=0003f804 idx=3 tag=ee", rsp_valid, rsp_data, rsp_idx, rsp_tag);
    end
  endtask

  task automatic test_bubbles();
    logic want;
    rsp_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      req_valid = (k < 8 && k % 2 == 0) ? 4'b0100 : 4'b0000;
      if (req_valid[2]) begin
        req_data[128 +: 64] = {$urandom(), $urandom()};
        req_tag[16 +: 8] = 8'(8'h20 + k);
      end
      sample();
      if (k >= 3) begin
        want = ((k - 3) % 2 == 0);
        total++;
        if (rsp_valid !== want || (want && rsp_idx !== 2'd2)) begin
          bad++; $display("FAIL bubble k=%0d got v=%b idx=%0d want v=%b idx=2", k, rsp_valid, rsp_idx, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b1;
    req_data[0 +: 64] = {$urandom(), $urandom()};
    req_data[64 +: 64] = {$urandom(), $urandom()};
    req_data[192 +: 64] = {$urandom(), $urandom()};
    req_tag[7:0] = 8'h30; req_tag[15:8] = 8'h31; req_tag[31:24] = 8'h33;
    for (int k = 0; k < 4; k++) begin
      tick();
      req_valid = 4'b0011;
      sample();
    end
    total++; if ({rsp_valid, idle} !== 2'b10) begin bad++; $display("FAIL rstmid_pre got v,idle=%b want=10", {rsp_valid, idle}); end
    tick();
    reset = 1'b0; req_valid = 4'b1001;
    sample();
    total++; if ({req_ready, pe_enable} !== 5'b0) begin bad++; $display("FAIL rstmid_during got ready=%b en=%b want 0000/0", req_ready, pe_enable); end
    tick();
    reset = 1'b1;
    sample();
    total++; if ({rsp_valid, idle} !== 2'b01) begin bad++; $display("FAIL rstmid_after got v,idle=%b want=01", {rsp_valid, idle}); end
    total++; if (stall_count !== 32'd0) begin bad++; $display("FAIL rstmid_stall got=%0d want=0", stall_count); end
    total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL rstmid_first got=%b want=0001", req_ready); end
    tick(); sample();
    total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL rstmid_second got=%b want=1000", req_ready); end
    tick();
    req_valid = 4'b0;
  endtask

  task automatic test_drain();
    rsp_ready = 1'b1;
    sample();
    for (int n = 0; n < 20 && idle !== 1'b1; n++) begin tick(); sample(); end
    total++; if (idle !== 1'b1) begin bad++; $display("FAIL drain_idle got=%b want=1", idle); end
    total++; if (q.size() != 0) begin bad++; $display("FAIL drain_queue got=%0d want=0", q.size()); end
  endtask

  initial begin
    reset = 1'b0; req_valid = '0; req_data = '0; req_tag = '0; rsp_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_single();
    test_backpressure();
    test_max();
    test_bubbles();
    test_reset_mid();
    test_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
